// File: rtl/vend_buyer_if.sv
// Buyer <-> requester/vending-machine signal bundle.
// master: the buyer block; slave: the requester plus vending machine side.
interface vend_buyer_if;
    logic              req_valid;
    logic [1:0]        req_item;
    logic [3:0]        req_n10;
    logic [3:0]        req_n50;
    logic              req_ready;
    logic [1:0]        item;
    logic              sel;
    logic              dollar_10;
    logic              dollar_50;
    logic signed [3:0] price;
    logic [2:0]        item_rels;
    logic              change_return;
    logic              done;
    logic [1:0]        done_item;
    logic [3:0]        done_change;
    logic [1:0]        done_err;

    modport master (
        input  req_valid, req_item, req_n10, req_n50, price, item_rels, change_return,
        output req_ready, item, sel, dollar_10, dollar_50,
               done, done_item, done_change, done_err
    );

    modport slave (
        output req_valid, req_item, req_n10, req_n50, price, item_rels, change_return,
        input  req_ready, item, sel, dollar_10, dollar_50,
               done, done_item, done_change, done_err
    );
endinterface

// File: rtl/vend_buyer.sv
// Purchase sequencer: selects an item on the vending machine, feeds coins
// until the price is covered, collects the item and change, reports result.
module vend_buyer (
    input  logic         clk,
    input  logic         reset,
    vend_buyer_if.master bus
);
    localparam int unsigned ITEM_W = 2;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned ERR_W  = 2;

    localparam logic [ERR_W-1:0] ERR_NONE    = 2'b00;
    localparam logic [ERR_W-1:0] ERR_FUNDS   = 2'b01;
    localparam logic [ERR_W-1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [ERR_W-1:0] ERR_ITEM    = 2'b11;

    typedef enum logic [2:0] {
        IDLE, SELECT, SETTLE0, COIN, SETTLE, COLLECT, DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ITEM_W-1:0]  item_q, item_d;
    logic [CNT_W-1:0]   n10_q, n10_d;
    logic [CNT_W-1:0]   n50_q, n50_d;
    logic [CNT_W-1:0]   chg_q, chg_d;
    logic [CNT_W-1:0]   tmo_q, tmo_d;
    logic               rel_q, rel_d;
    logic [ITEM_W-1:0]  rel_item_q, rel_item_d;

    logic               req_ready_q, req_ready_d;
    logic [ITEM_W-1:0]  item_out_q, item_out_d;
    logic               sel_q, sel_d;
    logic               d10_q, d10_d;
    logic               d50_q, d50_d;
    logic               done_q, done_d;
    logic [ITEM_W-1:0]  done_item_q, done_item_d;
    logic [CNT_W-1:0]   done_change_q, done_change_d;
    logic [ERR_W-1:0]   done_err_q, done_err_d;

    logic               go_done;
    logic [ERR_W-1:0]   err_sel;
    logic               price_le0, price_ge0, price_ge5;

    assign price_le0 = ($signed(bus.price) <= 4'sd0);
    assign price_ge0 = ($signed(bus.price) >= 4'sd0);
    assign price_ge5 = ($signed(bus.price) >= 4'sd5);

    // State, working registers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            item_q        <= '0;
            n10_q         <= '0;
            n50_q         <= '0;
            chg_q         <= '0;
            tmo_q         <= '0;
            rel_q         <= 1'b0;
            rel_item_q    <= '0;
            req_ready_q   <= 1'b1;
            item_out_q    <= '0;
            sel_q         <= 1'b0;
            d10_q         <= 1'b0;
            d50_q         <= 1'b0;
            done_q        <= 1'b0;
            done_item_q   <= '0;
            done_change_q <= '0;
            done_err_q    <= '0;
        end else begin
            state_q       <= state_d;
            item_q        <= item_d;
            n10_q         <= n10_d;
            n50_q         <= n50_d;
            chg_q         <= chg_d;
            tmo_q         <= tmo_d;
            rel_q         <= rel_d;
            rel_item_q    <= rel_item_d;
            req_ready_q   <= req_ready_d;
            item_out_q    <= item_out_d;
            sel_q         <= sel_d;
            d10_q         <= d10_d;
            d50_q         <= d50_d;
            done_q        <= done_d;
            done_item_q   <= done_item_d;
            done_change_q <= done_change_d;
            done_err_q    <= done_err_d;
        end
    end

    // Next-state, working-register updates and next output values.
    always_comb begin
        state_d       = state_q;
        item_d        = item_q;
        n10_d         = n10_q;
        n50_d         = n50_q;
        chg_d         = chg_q;
        tmo_d         = tmo_q;
        rel_d         = rel_q;
        rel_item_d    = rel_item_q;
        d10_d         = 1'b0;
        d50_d         = 1'b0;
        done_d        = 1'b0;
        done_item_d   = done_item_q;
        done_change_d = done_change_q;
        done_err_d    = done_err_q;
        go_done       = 1'b0;
        err_sel       = ERR_NONE;

        // Release and change are observed while paying and while collecting.
        if (state_q == SETTLE || state_q == COLLECT) begin
            if (bus.item_rels[2]) begin
                rel_d      = 1'b1;
                rel_item_d = bus.item_rels[1:0];
            end
            if (bus.change_return && chg_q != CNT_W'(15)) begin
                chg_d = chg_q + CNT_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    item_d     = bus.req_item;
                    n10_d      = bus.req_n10;
                    n50_d      = bus.req_n50;
                    chg_d      = '0;
                    rel_d      = 1'b0;
                    rel_item_d = '0;
                    tmo_d      = '0;
                    state_d    = SELECT;
                end
            end
            SELECT:  state_d = SETTLE0;
            SETTLE0: state_d = SETTLE;
            SETTLE: begin
                if (price_le0) begin
                    tmo_d   = '0;
                    state_d = COLLECT;
                end else if (price_ge5 && n50_q != '0) begin
                    d50_d   = 1'b1;
                    n50_d   = n50_q - CNT_W'(1);
                    state_d = COIN;
                end else if (n10_q != '0) begin
                    d10_d   = 1'b1;
                    n10_d   = n10_q - CNT_W'(1);
                    state_d = COIN;
                end else if (n50_q != '0) begin
                    d50_d   = 1'b1;
                    n50_d   = n50_q - CNT_W'(1);
                    state_d = COIN;
                end else begin
                    go_done = 1'b1;
                    err_sel = ERR_FUNDS;
                end
            end
            COIN: state_d = SETTLE;
            COLLECT: begin
                if (rel_d && price_ge0 && !bus.change_return) begin
                    go_done = 1'b1;
                end else if (tmo_q == CNT_W'(15)) begin
                    go_done = 1'b1;
                    err_sel = ERR_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Completion: latch the result, flagging a wrong released item.
        if (go_done) begin
            state_d       = DONE;
            done_d        = 1'b1;
            done_item_d   = rel_item_d;
            done_change_d = chg_d;
            if (err_sel == ERR_NONE && rel_d && rel_item_d != item_q) begin
                done_err_d = ERR_ITEM;
            end else begin
                done_err_d = err_sel;
            end
        end

        req_ready_d = (state_d == IDLE);
        sel_d       = (state_d == SELECT);
        item_out_d  = (state_d == IDLE) ? '0 : item_d;
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.item        = item_out_q;
    assign bus.sel         = sel_q;
    assign bus.dollar_10   = d10_q;
    assign bus.dollar_50   = d50_q;
    assign bus.done        = done_q;
    assign bus.done_item   = done_item_q;
    assign bus.done_change = done_change_q;
    assign bus.done_err    = done_err_q;
endmodule

// File: tb/tb_vend_buyer.sv
// Bench for vend_buyer: behavioural vending machine plus purchase-level reference.
module tb_vend_buyer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vend_buyer_if bus ();
    vend_buyer dut (.clk(clk), .reset(reset), .bus(bus.master));

    int n_checks = 0;
    int n_fail   = 0;

    // Machine mode: 0 normal, 1 releases the wrong item, 2 never releases.
    int         m_mode = 0;
    int         m_price = 0;
    bit         m_active = 0;
    bit         m_released = 0;
    logic [1:0] m_item = 2'b00;

    // Vending machine: reacts to buyer outputs, drives price/release/change.
    always @(negedge clk) begin
        if (reset) begin
            m_price = 0; m_active = 0; m_released = 0;
            bus.item_rels = 3'b000; bus.change_return = 1'b0; bus.price = 4'sd0;
        end else begin
            bus.item_rels = 3'b000;
            bus.change_return = 1'b0;
            if (m_active && !m_released && m_price <= 0 && m_mode != 2) begin
                bus.item_rels = {1'b1, (m_mode == 1) ? (m_item ^ 2'b01) : m_item};
                m_released = 1;
            end else if (m_released && m_price < 0) begin
                bus.change_return = 1'b1;
                m_price++;
            end
            if (bus.sel) begin
                m_item = bus.item; m_price = int'(bus.item) + 2;
                m_active = 1; m_released = 0;
            end
            if (bus.dollar_10) m_price -= 1;
            if (bus.dollar_50) m_price -= 5;
            bus.price = 4'(m_price);
        end
    end

    // Purchase-level reference: coin sequence (bit=1 means $50) and result.
    task automatic ref_model(input logic [1:0] it, input int n10, input int n50, input int mode,
                             output int nc, output logic [15:0] seq, output logic [1:0] err,
                             output int chg, output logic [1:0] ditem);
        int p;
        p = int'(it) + 2; nc = 0; seq = '0; err = 2'b00; chg = 0; ditem = 2'b00;
        while (p > 0 && err == 2'b00) begin
            if (p >= 5 && n50 > 0)      begin seq[nc] = 1'b1; n50--; p -= 5; nc++; end
            else if (n10 > 0)           begin n10--; p -= 1; nc++; end
            else if (n50 > 0)           begin seq[nc] = 1'b1; n50--; p -= 5; nc++; end
            else                        err = 2'b01;
        end
        if (err == 2'b00) begin
            if (mode == 2) err = 2'b10;
            else begin
                chg = -p;
                err = (mode == 1) ? 2'b11 : 2'b00;
                ditem = (mode == 1) ? (it ^ 2'b01) : it;
            end
        end
    endtask

    task automatic wait_ready(input string name);
        for (int i = 0; i < 50 && bus.req_ready !== 1'b1; i++) @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s ready_wait: req_ready=%b required 1", name, bus.req_ready);
        end
    endtask

    task automatic run_purchase(input logic [1:0] it, input int n10, input int n50,
                                input int mode, input string name);
        int nc_e, chg_e, nc, cyc, sels, bad;
        logic [15:0] seq_e, seq;
        logic [1:0] err_e, item_e;
        bit seen, prev_coin;
        ref_model(it, n10, n50, mode, nc_e, seq_e, err_e, chg_e, item_e);
        m_mode = mode;
        wait_ready(name);
        bus.req_valid = 1'b1; bus.req_item = it;
        bus.req_n10 = 4'(n10); bus.req_n50 = 4'(n50);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_item = 2'($urandom); bus.req_n10 = 4'($urandom); bus.req_n50 = 4'($urandom);
        nc = 0; seq = '0; sels = 0; bad = 0; seen = 0; prev_coin = 0; cyc = 0;
        for (cyc = 0; cyc < 200; cyc++) begin
            if (bus.sel) sels++;
            if (bus.dollar_10 && bus.dollar_50) bad++;
            if (bus.dollar_10 || bus.dollar_50) begin
                if (prev_coin) bad++;
                if (nc < 16) seq[nc] = bus.dollar_50;
                nc++;
            end
            if (bus.req_ready) bad++;
            prev_coin = bus.dollar_10 || bus.dollar_50;
            if (bus.done) begin seen = 1; break; end
            @(negedge clk);
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL %s done_wait: no done in 200 cycles", name); end
        n_checks++;
        if (nc !== nc_e || seq !== seq_e) begin
            n_fail++; $display("FAIL %s coins: got n=%0d seq=%h required n=%0d seq=%h", name, nc, seq, nc_e, seq_e);
        end
        n_checks++;
        if (bus.done_err !== err_e) begin
            n_fail++; $display("FAIL %s err: got %b required %b", name, bus.done_err, err_e);
        end
        n_checks++;
        if (bus.done_change !== 4'(chg_e)) begin
            n_fail++; $display("FAIL %s change: got %0d required %0d", name, bus.done_change, chg_e);
        end
        if (err_e == 2'b00 || err_e == 2'b11) begin
            n_checks++;
            if (bus.done_item !== item_e) begin
                n_fail++; $display("FAIL %s done_item: got %b required %b", name, bus.done_item, item_e);
            end
        end
        if (err_e == 2'b10) begin
            n_checks++;
            if (cyc !== 19 + 2 * nc_e) begin
                n_fail++; $display("FAIL %s timeout_latency: got %0d required %0d", name, cyc, 19 + 2 * nc_e);
            end
        end
        n_checks++;
        if (sels !== 1 || bad !== 0) begin
            n_fail++; $display("FAIL %s protocol: sel pulses=%0d violations=%0d required 1/0", name, sels, bad);
        end
        @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b0 || bus.req_ready !== 1'b1 || bus.done_err !== err_e) begin
            n_fail++; $display("FAIL %s after_done: done=%b ready=%b err=%b required 0/1/%b",
                               name, bus.done, bus.req_ready, bus.done_err, err_e);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_item = 2'b00; bus.req_n10 = 4'd0; bus.req_n50 = 4'd0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.item, bus.sel, bus.dollar_10, bus.dollar_50, bus.done, bus.done_item,
             bus.done_change, bus.done_err} !== 15'd0) begin
            n_fail++; $display("FAIL reset_outputs: got item=%b sel=%b d10=%b d50=%b done=%b required all 0",
                               bus.item, bus.sel, bus.dollar_10, bus.dollar_50, bus.done);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b required 1", bus.req_ready);
        end
    endtask

    task automatic test_directed();
        run_purchase(2'b00, 3, 0, 0, "water_10s");
        run_purchase(2'b01, 0, 1, 0, "tea_50_change");
        run_purchase(2'b11, 5, 1, 0, "juice_one_50");
        run_purchase(2'b10, 2, 0, 0, "coke_short");
        run_purchase(2'b11, 5, 1, 2, "juice_timeout");
        run_purchase(2'b01, 3, 0, 1, "tea_wrong_item");
        run_purchase(2'b10, 0, 0, 0, "coke_no_coins");
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            int md;
            md = ($urandom_range(0, 5) == 0) ? 2 : (($urandom_range(0, 5) == 0) ? 1 : 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_purchase(2'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(0, 2)), md, "random");
        end
    endtask

    task automatic test_back_to_back();
        int dones, sels, first, gap;
        m_mode = 0;
        wait_ready("b2b");
        bus.req_valid = 1'b1; bus.req_item = 2'b00; bus.req_n10 = 4'd3; bus.req_n50 = 4'd0;
        dones = 0; sels = 0; first = 0; gap = 0;
        for (int c = 0; c < 100 && dones < 2; c++) begin
            @(negedge clk);
            if (bus.sel) sels++;
            if (bus.done) begin
                dones++;
                if (dones == 1) first = c; else gap = c - first;
            end
        end
        bus.req_valid = 1'b0;
        n_checks++;
        if (dones !== 2 || sels !== 2 || gap !== 10) begin
            n_fail++; $display("FAIL b2b: dones=%0d sels=%0d gap=%0d required 2/2/10", dones, sels, gap);
        end
        n_checks++;
        if (bus.done_err !== 2'b00 || bus.done_item !== 2'b00) begin
            n_fail++; $display("FAIL b2b_result: err=%b item=%b required 00/00", bus.done_err, bus.done_item);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_coin();
        bit hit;
        m_mode = 0;
        wait_ready("rst_coin");
        bus.req_valid = 1'b1; bus.req_item = 2'b00; bus.req_n10 = 4'd3; bus.req_n50 = 4'd0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        hit = 0;
        for (int c = 0; c < 20 && !hit; c++) begin
            if (bus.dollar_10 || bus.dollar_50) hit = 1; else @(negedge clk);
        end
        n_checks++;
        if (!hit) begin n_fail++; $display("FAIL rst_coin_reach: no coin pulse seen"); end
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.sel, bus.dollar_10, bus.dollar_50, bus.done, bus.item} !== 6'd0) begin
            n_fail++; $display("FAIL rst_coin_outputs: sel=%b d10=%b d50=%b done=%b item=%b required 0",
                               bus.sel, bus.dollar_10, bus.dollar_50, bus.done, bus.item);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b1 || bus.dollar_10 !== 1'b0) begin
            n_fail++; $display("FAIL rst_coin_ready: ready=%b d10=%b required 1/0", bus.req_ready, bus.dollar_10);
        end
        run_purchase(2'b10, 4, 0, 0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid_coin();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
